// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, word width, error response value and the address check.
// No logic of its own; imported by dmem_array and dmem_responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [WORD_W-1:0] ERR_RDATA = 32'h0;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } req_t;

    // Misaligned, or any byte-address bit above the word index set.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int depth_log2);
        logic [WORD_W-1:0] hi_mask;
        hi_mask = ~((32'd1 << (depth_log2 + 2)) - 32'd1);
        return (addr[1:0] != 2'b00) || ((addr & hi_mask) != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; contents are never reset.
// Latency: write commits and read data registers on the enabled edge.
// Backpressure: none; the caller pulses en once per access.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // rdata holds its value between reads, which keeps a load response stable.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage loads/stores, one transaction in flight.
// Latency: resp_valid rises LATENCY edges after the accept edge.
// Backpressure: response held until resp_ready; req_ready low from accept to handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    req_t              req_q;
    logic              err_q;
    logic              ld_q;
    logic              req_err;
    logic              access;
    logic [WORD_W-1:0] ram_rdata;

    assign req_err = addr_err(req_q.addr, DEPTH_LOG2);
    assign access  = (state == ST_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            req_q <= '0;
            err_q <= 1'b0;
            ld_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
                        cnt   <= CNT_INIT;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err_q <= req_err;
                        ld_q  <= !req_q.we && !req_err;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        err_q <= 1'b0;
                        ld_q  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Erroring requests never touch the array, so a bad store cannot corrupt memory.
    dmem_array #(
        .DEPTH (2 ** DEPTH_LOG2),
        .IDX_W (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .en    (access && !req_err),
        .we    (req_q.we),
        .idx   (req_q.addr[DEPTH_LOG2+1:2]),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    assign req_ready  = rst && (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = err_q;
    assign resp_rdata = ld_q ? ram_rdata : ERR_RDATA;
    assign busy       = (state != ST_IDLE);

endmodule
